// File: rtl/distortion_multimode.sv
// distortion_multimode: gain -> clip (4 modes) -> volume on a time-multiplexed
// stream of signed samples. Four register stages; each sample carries its own
// settings, channel tag and enable bit so in-flight samples never see a later
// frame's controls.
//
// Handshake: valid-only streaming. in_valid marks a sample on the current
// cycle, there is no ready, the pipeline advances every cycle and out_valid
// marks a result exactly four edges after the input was driven. out and
// out_channel hold their last valid values while out_valid is low.
module distortion_multimode #(
  parameter int WIDTH     = 24,
  parameter int GAIN_FRAC = 20,
  parameter int VOL_FRAC  = WIDTH - 1,
  parameter int CHANNELS  = 2,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  input  logic [CW-1:0]           in_channel,
  input  logic signed [WIDTH-1:0] in,
  input  logic [WIDTH-1:0]        gain,
  input  logic [WIDTH-1:0]        threshold,
  input  logic [WIDTH-1:0]        volume,
  output logic                    out_valid,
  output logic [CW-1:0]           out_channel,
  output logic signed [WIDTH-1:0] out
);

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] GAIN_ONE = WIDTH'(1) << GAIN_FRAC;
  localparam logic [WIDTH-1:0] VOL_ONE  = WIDTH'(1) << VOL_FRAC;

  // Saturate a double-width value into the signed sample range.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [2*WIDTH-1:0] v);
    logic [WIDTH:0] top;
    top = v[2*WIDTH-1:WIDTH-1];
    if ((&top) || !(|top)) return v[WIDTH-1:0];
    return v[2*WIDTH-1] ? SMIN : SMAX;
  endfunction

  // Shadow control registers and the settings that apply to the incoming sample
  logic [WIDTH-1:0] sh_gain, sh_thr, sh_vol;
  logic [1:0]       sh_mode;
  logic             load;
  logic [WIDTH-1:0] eff_gain, eff_thr, eff_vol;
  logic [1:0]       eff_mode;

  // A frame-start sample uses the fresh controls itself; others use the shadow.
  always_comb begin
    load     = in_valid && (in_channel == '0);
    eff_gain = sh_gain;
    eff_thr  = sh_thr;
    eff_vol  = sh_vol;
    eff_mode = sh_mode;
    if (load) begin
      eff_gain = gain;
      eff_thr  = threshold[WIDTH-1] ? SMAX : threshold;
      eff_vol  = volume;
      eff_mode = mode;
    end
  end

  // Shadow registers load only on a frame-start sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_gain <= GAIN_ONE;
      sh_thr  <= SMAX;
      sh_vol  <= VOL_ONE;
      sh_mode <= 2'b00;
    end else if (load) begin
      sh_gain <= eff_gain;
      sh_thr  <= eff_thr;
      sh_vol  <= eff_vol;
      sh_mode <= eff_mode;
    end
  end

  // Stage registers
  logic                    s1_valid, s2_valid, s3_valid;
  logic [CW-1:0]           s1_ch, s2_ch, s3_ch;
  logic                    s1_en, s2_en, s3_en;
  logic [1:0]              s1_mode, s2_mode;
  logic signed [WIDTH-1:0] s1_raw, s2_raw, s3_raw;
  logic [WIDTH-1:0]        s1_gain, s1_thr, s2_thr, s1_vol, s2_vol, s3_vol;
  logic signed [WIDTH-1:0] s2_x, s3_y;

  // Gain: full signed product, floor shift, saturate.
  logic signed [2*WIDTH-1:0] g_prod, g_sh;
  always_comb begin
    g_prod = $signed({{WIDTH{s1_raw[WIDTH-1]}}, s1_raw}) * $signed({{WIDTH{1'b0}}, s1_gain});
    g_sh   = g_prod >>> GAIN_FRAC;
  end

  // Clip on the gained value according to the sample's mode.
  logic signed [WIDTH-1:0] t_s, half_s, abs_x, clip_y;
  always_comb begin
    t_s    = $signed(s2_thr);
    half_s = $signed(s2_thr >> 1);
    abs_x  = (s2_x == SMIN) ? SMAX : (s2_x[WIDTH-1] ? -s2_x : s2_x);
    clip_y = s2_x;
    case (s2_mode)
      2'b01:   clip_y = (s2_x > t_s) ? t_s : ((s2_x < -t_s) ? -t_s : s2_x);
      2'b10:   clip_y = (s2_x > t_s) ? t_s : ((s2_x < -half_s) ? -half_s : s2_x);
      2'b11:   clip_y = (abs_x > t_s) ? t_s : abs_x;
      default: clip_y = s2_x;
    endcase
  end

  // Volume: same floor/saturate rule as gain; bypass returns the raw sample.
  logic signed [2*WIDTH-1:0] v_prod, v_sh;
  logic signed [WIDTH-1:0]   final_y;
  always_comb begin
    v_prod  = $signed({{WIDTH{s3_y[WIDTH-1]}}, s3_y}) * $signed({{WIDTH{1'b0}}, s3_vol});
    v_sh    = v_prod >>> VOL_FRAC;
    final_y = s3_en ? sat_w(v_sh) : s3_raw;
  end

  // Pipeline advance: valid bits clear on reset, payload follows its sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0;
      s1_ch <= '0; s2_ch <= '0; s3_ch <= '0;
      s1_en <= 1'b0; s2_en <= 1'b0; s3_en <= 1'b0;
      s1_mode <= 2'b00; s2_mode <= 2'b00;
      s1_raw <= '0; s2_raw <= '0; s3_raw <= '0;
      s1_gain <= '0; s1_thr <= '0; s2_thr <= '0;
      s1_vol <= '0; s2_vol <= '0; s3_vol <= '0;
      s2_x <= '0; s3_y <= '0;
    end else begin
      s1_valid <= in_valid;  s1_ch <= in_channel; s1_en <= enable;
      s1_mode  <= eff_mode;  s1_raw <= in;
      s1_gain  <= eff_gain;  s1_thr <= eff_thr;  s1_vol <= eff_vol;

      s2_valid <= s1_valid;  s2_ch <= s1_ch;     s2_en <= s1_en;
      s2_mode  <= s1_mode;   s2_raw <= s1_raw;   s2_x <= sat_w(g_sh);
      s2_thr   <= s1_thr;    s2_vol <= s1_vol;

      s3_valid <= s2_valid;  s3_ch <= s2_ch;     s3_en <= s2_en;
      s3_raw   <= s2_raw;    s3_y <= clip_y;     s3_vol <= s2_vol;
    end
  end

  // Output register: updates only on valid samples, holds through bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out         <= '0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_channel <= s3_ch;
        out         <= final_y;
      end
    end
  end

endmodule

// File: tb/tb_distortion_multimode.sv
// Bench for distortion_multimode: arithmetic model of the sample path plus a
// per-cycle compare process against an expected queue.
module tb_distortion_multimode;
  localparam int W  = 24;
  localparam int GF = 20;
  localparam int VF = 23;
  localparam int CW = 1;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_channel = '0;
  logic [W-1:0]  dut_in = '0, gain = '0, threshold = '0, volume = '0;
  logic          out_valid;
  logic [CW-1:0] out_channel;
  logic [W-1:0]  dut_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] ch_q[$];
  int            due_q[$];
  logic [W-1:0]  last_out = '0;
  logic [CW-1:0] last_ch = '0;

  longint m_gain = 64'sd1 <<< GF;
  longint m_thr  = MAXV;
  longint m_vol  = 64'sd1 <<< VF;
  int     m_mode = 0;

  distortion_multimode #(.WIDTH(W), .GAIN_FRAC(GF), .VOL_FRAC(VF), .CHANNELS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .in_valid(in_valid), .in_channel(in_channel), .in(dut_in),
    .gain(gain), .threshold(threshold), .volume(volume),
    .out_valid(out_valid), .out_channel(out_channel), .out(dut_out)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sat_l(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Sample-path model in plain integer arithmetic.
  function automatic longint model(input longint x, input bit en, input int md,
                                   input longint g, input longint t, input longint v);
    longint xg, tt, y, a;
    if (!en) return x;
    xg = sat_l((x * g) >>> GF);
    tt = (t > MAXV) ? MAXV : t;
    case (md)
      1: y = (xg > tt) ? tt : ((xg < -tt) ? -tt : xg);
      2: y = (xg > tt) ? tt : ((xg < -(tt / 2)) ? -(tt / 2) : xg);
      3: begin
        a = (xg < 0) ? -xg : xg;
        if (a > MAXV) a = MAXV;
        y = (a > tt) ? tt : a;
      end
      default: y = xg;
    endcase
    return sat_l((y * v) >>> VF);
  endfunction

  // Driver: one cycle of stimulus; valid samples are modelled and queued.
  task automatic send(input bit v, input logic [CW-1:0] ch, input bit en, input logic [1:0] md,
                      input logic [W-1:0] x, input logic [W-1:0] g, input logic [W-1:0] t,
                      input logic [W-1:0] vol, input bit pin, input logic [W-1:0] lit);
    longint r;
    logic [W-1:0] rw;
    @(posedge clk); #1;
    in_valid = v; in_channel = ch; enable = en; mode = md;
    dut_in = x; gain = g; threshold = t; volume = vol;
    if (v) begin
      if (ch == '0) begin
        m_gain = longint'(g); m_thr = longint'(t); m_vol = longint'(vol); m_mode = int'(md);
      end
      r  = model(longint'($signed(x)), en, m_mode, m_gain, m_thr, m_vol);
      rw = r[W-1:0];
      if (pin) begin
        total++;
        if (rw !== lit) begin
          bad++;
          $display("FAIL model_pin x=%h got=%h want=%h", x, rw, lit);
        end
      end
      exp_q.push_back(rw);
      ch_q.push_back(ch);
      due_q.push_back(cyc + 4);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, '0, 1'b0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (out_valid !== 1'b0 || dut_out !== '0 || out_channel !== '0) begin
      bad++;
      $display("FAIL %s valid=%b out=%h ch=%h want 0/0/0", name, out_valid, dut_out, out_channel);
    end
  endtask

  // Scoreboard: every cycle out of reset, check valid timing, data and hold.
  initial begin
    logic [W-1:0]  e;
    logic [CW-1:0] c;
    forever begin
      @(posedge clk); #3;
      if (reset) begin
        total++;
        if (out_valid) begin
          if (due_q.size() == 0 || due_q[0] != cyc) begin
            bad++;
            $display("FAIL unexpected_valid cyc=%0d out=%h", cyc, dut_out);
          end else begin
            e = exp_q.pop_front(); c = ch_q.pop_front(); void'(due_q.pop_front());
            if (dut_out !== e || out_channel !== c) begin
              bad++;
              $display("FAIL sample cyc=%0d out=%h ch=%h want out=%h ch=%h", cyc, dut_out, out_channel, e, c);
            end
            last_out = e; last_ch = c;
          end
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
          bad++;
          e = exp_q.pop_front(); c = ch_q.pop_front(); void'(due_q.pop_front());
          $display("FAIL missing_valid cyc=%0d want out=%h ch=%h", cyc, e, c);
          last_out = e; last_ch = c;
        end else if (dut_out !== last_out || out_channel !== last_ch) begin
          bad++;
          $display("FAIL hold cyc=%0d out=%h ch=%h want out=%h ch=%h", cyc, dut_out, out_channel, last_out, last_ch);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset_state");
    @(posedge clk); #1 reset = 1'b1;
    idle(2);

    // Hard clip
    send(1, 0, 1, 2'b01, 24'h100000, 24'h200000, 24'h180000, 24'h800000, 1, 24'h180000);
    send(1, 1, 1, 2'b01, 24'hF00000, 24'h200000, 24'h180000, 24'h800000, 1, 24'hE80000);
    idle(5);

    // Saturation and volume floor
    send(1, 0, 1, 2'b00, 24'h7FFFFF, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 1, 24'h7FFFFF);
    send(1, 1, 1, 2'b00, 24'h800000, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 1, 24'h800000);
    send(1, 0, 1, 2'b00, 24'h200000, 24'h100000, 24'h7FFFFF, 24'h400000, 1, 24'h100000);
    send(1, 1, 1, 2'b00, 24'hFFFFFD, 24'h100000, 24'h7FFFFF, 24'h400000, 1, 24'hFFFFFE);
    idle(2);

    // Asymmetric clip, fuzz, oversized threshold
    send(1, 0, 1, 2'b10, 24'hE00000, 24'h100000, 24'h100000, 24'h800000, 1, 24'hF80000);
    send(1, 1, 1, 2'b10, 24'h200000, 24'h100000, 24'h100000, 24'h800000, 1, 24'h100000);
    send(1, 0, 1, 2'b11, 24'h800000, 24'h100000, 24'h100000, 24'h800000, 1, 24'h100000);
    send(1, 0, 1, 2'b11, 24'h800000, 24'h100000, 24'h7FFFFF, 24'h800000, 1, 24'h7FFFFF);
    send(1, 0, 1, 2'b01, 24'h7FFFFF, 24'h100000, 24'hFFFFFF, 24'h800000, 1, 24'h7FFFFF);
    send(1, 1, 1, 2'b01, 24'h800000, 24'h100000, 24'hFFFFFF, 24'h800000, 1, 24'h800001);
    idle(3);

    // Frame-boundary update: gain change presented on ch1 waits for next ch0
    send(1, 0, 1, 2'b00, 24'h010000, 24'h100000, 24'h7FFFFF, 24'h800000, 1, 24'h010000);
    send(1, 1, 1, 2'b00, 24'h010000, 24'h200000, 24'h7FFFFF, 24'h800000, 1, 24'h010000);
    send(1, 0, 1, 2'b00, 24'h010000, 24'h200000, 24'h7FFFFF, 24'h800000, 1, 24'h020000);
    send(1, 1, 1, 2'b00, 24'h010000, 24'h100000, 24'h7FFFFF, 24'h800000, 1, 24'h020000);
    idle(1);

    // Enable alternating on consecutive samples
    send(1, 0, 1, 2'b01, 24'h005000, 24'h100000, 24'h001000, 24'h800000, 1, 24'h001000);
    send(1, 1, 0, 2'b01, 24'h005000, 24'h100000, 24'h001000, 24'h800000, 1, 24'h005000);
    send(1, 0, 1, 2'b01, 24'hFFB000, 24'h100000, 24'h001000, 24'h800000, 1, 24'hFFF000);
    send(1, 1, 0, 2'b01, 24'hFFB000, 24'h100000, 24'h001000, 24'h800000, 1, 24'hFFB000);
    idle(6);

    // Reset with three samples in flight
    send(1, 0, 1, 2'b01, 24'h050000, 24'h200000, 24'h001000, 24'h400000, 0, '0);
    send(1, 1, 1, 2'b01, 24'h060000, 24'h200000, 24'h001000, 24'h400000, 0, '0);
    send(1, 0, 1, 2'b01, 24'h070000, 24'h200000, 24'h001000, 24'h400000, 0, '0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete(); ch_q.delete(); due_q.delete();
    last_out = '0; last_ch = '0;
    m_gain = 64'sd1 <<< GF; m_thr = MAXV; m_vol = 64'sd1 <<< VF; m_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(6);
    send(1, 1, 1, 2'b11, 24'h123456, 24'h200000, 24'h000010, 24'h100000, 1, 24'h123456);
    idle(8);

    total++;
    if (due_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", due_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
